// File: rtl/sync_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: RUN/HALT state encoding,
// direction constants and the binary-to-Gray helper.
package sync_updown_counter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Generic 32-bit form; callers truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational modulo-MODULUS successor/predecessor of q, plus terminal and wrap detection.
// The up path is evaluated in WIDTH+1 bits so MODULUS = 2**WIDTH wraps without overflow.
module counter_next_val
    import sync_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             one_shot,
    output logic [WIDTH-1:0] next_val,
    output logic             at_terminal,
    output logic             wrap_now
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0]   inc;
    logic [WIDTH-1:0] nxt_up;
    logic [WIDTH-1:0] nxt_dn;
    logic [WIDTH-1:0] term;

    assign inc    = {1'b0, q} + (WIDTH+1)'(1);
    assign nxt_up = (inc == MOD_EXT) ? '0 : inc[WIDTH-1:0];
    assign nxt_dn = (q == '0) ? LAST : q - WIDTH'(1);

    assign term        = (up == DIR_DOWN) ? '0 : LAST;
    assign at_terminal = (q == term);
    assign wrap_now    = at_terminal & ~one_shot;

    // One-shot at terminal holds q; the top turns that into a HALT transition.
    always_comb begin
        next_val = q;
        if (!(at_terminal && one_shot)) begin
            next_val = (up == DIR_UP) ? nxt_up : nxt_dn;
        end
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-N up/down counter with load, one-shot HALT, terminal-count flag and wrap pulse.
// Optional registered Gray output q_gray when COUNTER_GRAY_EN is defined (needs MODULUS = 2**WIDTH).
module sync_updown_counter
    import sync_updown_counter_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int MODULUS   = 32,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
`ifdef COUNTER_GRAY_EN
    output logic [WIDTH-1:0] q_gray,
`endif
    output logic             tc,
    output logic             wrap,
    output logic             halted
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("sync_updown_counter: RESET_VAL %0d not below MODULUS", RESET_VAL);
    end

    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    state_e           state_q, state_d;

    logic [WIDTH-1:0] next_val;
    logic             at_terminal;
    logic             wrap_now;

    counter_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q           (q_q),
        .up          (up),
        .one_shot    (one_shot),
        .next_val    (next_val),
        .at_terminal (at_terminal),
        .wrap_now    (wrap_now)
    );

    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        state_d = state_q;
        if (load) begin
            q_d     = ({1'b0, load_val} < MOD_EXT) ? load_val : LAST;
            state_d = ST_RUN;
        end else if (en && state_q == ST_RUN) begin
            q_d    = next_val;
            wrap_d = wrap_now;
            if (at_terminal && one_shot) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q     <= RST_Q;
            wrap_q  <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            state_q <= state_d;
        end
    end

`ifdef COUNTER_GRAY_EN
    if (MODULUS != (2 ** WIDTH)) begin : g_bad_gray
        $error("sync_updown_counter: q_gray requires MODULUS == 2**WIDTH");
    end

    logic [WIDTH-1:0] q_gray_q;

    // Encoded from q_d so the Gray output never lags q.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_gray_q <= WIDTH'(bin2gray(32'(RST_Q)));
        end else begin
            q_gray_q <= WIDTH'(bin2gray(32'(q_d)));
        end
    end

    assign q_gray = q_gray_q;
`endif

    assign q      = q_q;
    assign wrap   = wrap_q;
    assign halted = (state_q == ST_HALT);
    assign tc     = en & at_terminal;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Two counters (default 32-count and a small-modulus one) driven in lockstep and compared each cycle
// with an arithmetic reference model; directed phases first, then random traffic.
module tb_sync_updown_counter;

`ifdef COUNTER_GRAY_EN
    localparam int BW = 4;
    localparam int BM = 16;
`else
    localparam int BW = 4;
    localparam int BM = 10;
`endif

    logic          clk = 1'b0;
    logic          clear, en, up, load, one_shot;
    logic [4:0]    lva;
    logic [BW-1:0] lvb;
    logic [4:0]    qa;
    logic [BW-1:0] qb;
    logic          tca, tcb, wrapa, wrapb, halta, haltb;
`ifdef COUNTER_GRAY_EN
    logic [4:0]    qga;
    logic [BW-1:0] qgb;
    logic [31:0]   prev_ga;
    bit            gstep;
`endif

    int tests = 0;
    int fails = 0;

    int mq[2];
    int mw[2];
    int mh[2];
    int mmod[2];

    always #5 clk = ~clk;

    sync_updown_counter u_a (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(lva),
        .one_shot(one_shot), .q(qa),
`ifdef COUNTER_GRAY_EN
        .q_gray(qga),
`endif
        .tc(tca), .wrap(wrapa), .halted(halta)
    );

    sync_updown_counter #(.WIDTH(BW), .MODULUS(BM), .RESET_VAL(0)) u_b (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(lvb),
        .one_shot(one_shot), .q(qb),
`ifdef COUNTER_GRAY_EN
        .q_gray(qgb),
`endif
        .tc(tcb), .wrap(wrapb), .halted(haltb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge for counter i.
    function automatic void model_step(int i, int lv);
        int m = mmod[i];
        int term = up ? m - 1 : 0;
        if (clear) begin
            mq[i] = 0; mw[i] = 0; mh[i] = 0;
        end else if (load) begin
            mq[i] = (lv < m) ? lv : m - 1;
            mh[i] = 0; mw[i] = 0;
        end else if (en && !mh[i]) begin
            if (mq[i] == term) begin
                if (one_shot) begin
                    mh[i] = 1; mw[i] = 0;
                end else begin
                    mq[i] = up ? 0 : m - 1;
                    mw[i] = 1;
                end
            end else begin
                mq[i] = up ? mq[i] + 1 : mq[i] - 1;
                mw[i] = 0;
            end
        end else begin
            mw[i] = 0;
        end
    endfunction

    function automatic int exp_tc(int i);
        return (en && mq[i] == (up ? mmod[i] - 1 : 0)) ? 1 : 0;
    endfunction

    task automatic tick(input string ph);
        @(posedge clk);
        model_step(0, int'(lva));
        model_step(1, int'(lvb));
        #1;
        chk({ph, ".a.q"}, 32'(qa), 32'(mq[0]));
        chk({ph, ".a.wrap"}, 32'(wrapa), 32'(mw[0]));
        chk({ph, ".a.halted"}, 32'(halta), 32'(mh[0]));
        chk({ph, ".a.tc"}, 32'(tca), 32'(exp_tc(0)));
        chk({ph, ".b.q"}, 32'(qb), 32'(mq[1]));
        chk({ph, ".b.wrap"}, 32'(wrapb), 32'(mw[1]));
        chk({ph, ".b.halted"}, 32'(haltb), 32'(mh[1]));
        chk({ph, ".b.tc"}, 32'(tcb), 32'(exp_tc(1)));
`ifdef COUNTER_GRAY_EN
        chk({ph, ".a.gray"}, 32'(qga), 32'(mq[0] ^ (mq[0] >> 1)));
        chk({ph, ".b.gray"}, 32'(qgb), 32'(mq[1] ^ (mq[1] >> 1)));
        if (gstep) chk({ph, ".a.gray_1bit"}, 32'($countones(32'(qga) ^ prev_ga)), 32'd1);
        prev_ga = 32'(qga);
`endif
    endtask

    initial begin
        mmod[0] = 32; mmod[1] = BM;
        for (int i = 0; i < 2; i++) begin mq[i] = 0; mw[i] = 0; mh[i] = 0; end
`ifdef COUNTER_GRAY_EN
        gstep = 1'b0; prev_ga = 0;
`endif
        clear = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; one_shot = 1'b0;
        lva = '0; lvb = '0;
        tick("reset");

        // Free-running up count through a full wrap.
        clear = 1'b0; en = 1'b1; up = 1'b1;
`ifdef COUNTER_GRAY_EN
        gstep = 1'b1;
`endif
        for (int i = 0; i < 33; i++) tick("up_run");
`ifdef COUNTER_GRAY_EN
        gstep = 1'b0;
`endif

        // Down count from reset.
        clear = 1'b1; tick("clr2");
        clear = 1'b0; up = 1'b0;
        for (int i = 0; i < 12; i++) tick("down_run");

        // One-shot halts at terminal, en toggling has no effect, load exits HALT.
        clear = 1'b1; tick("clr3");
        clear = 1'b0; up = 1'b1; one_shot = 1'b1;
        for (int i = 0; i < 12; i++) tick("oneshot");
        for (int i = 0; i < 4; i++) begin en = ~en; tick("halt_en"); end
        up = 1'b0; tick("halt_up");
        load = 1'b1; lva = 5'd3; lvb = BW'(3); tick("halt_load");
        load = 1'b0; en = 1'b1; up = 1'b1; tick("post_load");

        // Clamped load, then load beating count.
        load = 1'b1; lva = 5'd20; lvb = BW'(15); en = 1'b0; tick("clamp");
        en = 1'b1; tick("load_vs_en");
        load = 1'b0; one_shot = 1'b0;

        // clear wins over a simultaneous load.
        clear = 1'b1; tick("clr5");
        clear = 1'b0; up = 1'b1;
        for (int i = 0; i < 6; i++) tick("to6");
        clear = 1'b1; load = 1'b1; lva = 5'd2; lvb = BW'(2); tick("clr_load");
        clear = 1'b0; load = 1'b0;

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            clear    = ($urandom_range(0, 24) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            one_shot = ($urandom_range(0, 3) == 0);
            lva      = 5'($urandom);
            lvb      = BW'($urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
